// File: rtl/seq_pkg.sv
// Shared types for the note sequencer: song entry layout, FSM states and width constants.
// DEFAULT_TUNE is the built-in song used when no SONG parameter is supplied.
package seq_pkg;

    localparam int TONE_W  = 10;
    localparam int BEATS_W = 4;
    localparam int ENTRY_W = TONE_W + BEATS_W + 1;

    typedef struct packed {
        logic [TONE_W-1:0]  tone;
        logic [BEATS_W-1:0] beats;
        logic               last;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Entry 0 occupies the least significant bits; the top entry carries the last flag.
    localparam logic [8*ENTRY_W-1:0] DEFAULT_TUNE = {
        10'd523, 4'd2, 1'b1,
        10'd494, 4'd1, 1'b0,
        10'd440, 4'd1, 1'b0,
        10'd392, 4'd1, 1'b0,
        10'd349, 4'd1, 1'b0,
        10'd330, 4'd1, 1'b0,
        10'd294, 4'd1, 1'b0,
        10'd262, 4'd1, 1'b0
    };

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM: the entry at addr_in appears on data_out one clock later.
// Contents come from the flat SONG vector, entry i at bits [i*ENTRY_W +: ENTRY_W].
module song_rom
    import seq_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] SONG = '0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [ADDR_W-1:0]   addr_in,
    output logic [ENTRY_W-1:0]  data_out
);

    logic [ENTRY_W-1:0] w_mem [ROM_DEPTH];
    logic [ENTRY_W-1:0] r_data;

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_mem
        assign w_mem[g] = SONG[g*ENTRY_W +: ENTRY_W];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_data <= '0;
        end else begin
            r_data <= w_mem[addr_in];
        end
    end

    assign data_out = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Song sequencer: walks the song ROM, driving an oscillator's tone index and sample-step
// pulse, with per-note beat timing, an optional silent gap after each note and looping.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int STEP_DIV   = 2083,
    parameter int BEAT_STEPS = 6000,
    parameter int GAP_STEPS  = 480,
    parameter int ROM_DEPTH  = 64,
    parameter int IDX_W      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] SONG = (ROM_DEPTH*ENTRY_W)'(DEFAULT_TUNE)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              loop_in,
    output logic              step_out,
    output logic [TONE_W-1:0] tone_out,
    output logic              gate_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [IDX_W-1:0]  note_idx_out,
    output logic [2:0]        dbg_state_out
);

    localparam int DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int MAX_COUNT = (16*BEAT_STEPS > GAP_STEPS) ? 16*BEAT_STEPS : GAP_STEPS;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_STEPS > 0) ? GAP_STEPS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROM_DEPTH - 1);

    // Index of the final step pulse of a note; a beats field of zero means 16 beats.
    function automatic logic [CNT_W-1:0] play_last(input logic [BEATS_W-1:0] beats);
        logic [BEATS_W:0] eff;
        eff = (beats == '0) ? (BEATS_W+1)'(16) : {1'b0, beats};
        return CNT_W'(eff * BEAT_STEPS - 1);
    endfunction

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic                r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_play_last;
    logic                r_last;
    logic [IDX_W-1:0]    r_idx;
    logic [TONE_W-1:0]   r_tone;
    logic                r_gate;
    logic                r_busy;
    logic                r_done;

    logic [DIV_W-1:0]    w_div_next;
    logic [ENTRY_W-1:0]  w_rom_data;
    entry_t              w_rom;
    logic                w_adv;
    logic                w_wrap;

    song_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (IDX_W),
        .SONG      (SONG)
    ) u_rom (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .addr_in  (r_idx),
        .data_out (w_rom_data)
    );

    assign w_rom      = entry_t'(w_rom_data);
    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

    // r_step mirrors "divider == STEP_DIV-1", so it doubles as the counting strobe.
    assign w_adv  = r_step &&
                    (((r_state == S_PLAY) && (r_cnt == r_play_last) && (GAP_STEPS == 0)) ||
                     ((r_state == S_GAP)  && (r_cnt == GAP_LAST)));
    assign w_wrap = r_last || (r_idx == IDX_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div  <= '0;
            r_step <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_step <= (w_div_next == DIV_LAST);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_play_last <= '0;
            r_last      <= 1'b0;
            r_idx       <= '0;
            r_tone      <= '0;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && stop_in) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_tone  <= '0;
                r_gate  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_in && !stop_in) begin
                            r_state <= S_FETCH;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_tone      <= w_rom.tone;
                        r_gate      <= (w_rom.tone != '0);
                        r_last      <= w_rom.last;
                        r_play_last <= play_last(w_rom.beats);
                        r_cnt       <= '0;
                        r_state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (r_step) begin
                            if (r_cnt == r_play_last) begin
                                r_cnt   <= '0;
                                r_gate  <= 1'b0;
                                r_state <= S_GAP;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (r_step) begin
                            r_cnt <= (r_cnt == GAP_LAST) ? '0 : r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase

                // Advance decision overrides whatever the note/gap branch chose above.
                if (w_adv) begin
                    if (!w_wrap) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_FETCH;
                    end else if (loop_in) begin
                        r_idx   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_idx   <= '0;
                        r_tone  <= '0;
                        r_gate  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            end
        end
    end

    assign step_out      = r_step;
    assign tone_out      = r_tone;
    assign gate_out      = r_gate;
    assign busy_out      = r_busy;
    assign done_out      = r_done;
    assign note_idx_out  = r_idx;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with STEP_DIV=4, BEAT_STEPS=3, GAP_STEPS=2, ROM_DEPTH=4.
// Expected timelines are hand-derived edge numbers counted from reset release.
module tb_note_sequencer;

    localparam logic [59:0] SONG_A = {15'd0,
                                      10'd300, 4'd1, 1'b1,
                                      10'd0,   4'd2, 1'b0,
                                      10'd100, 4'd1, 1'b0};
    localparam logic [59:0] SONG_B = {45'd0, 10'd200, 4'd0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop;

    logic       a_step, a_gate, a_busy, a_done;
    logic [9:0] a_tone;
    logic [1:0] a_idx;
    logic [2:0] a_state;
    logic       b_step, b_gate, b_busy, b_done;
    logic [9:0] b_tone;
    logic [1:0] b_idx;
    logic [2:0] b_state;

    note_sequencer #(
        .STEP_DIV(4), .BEAT_STEPS(3), .GAP_STEPS(2), .ROM_DEPTH(4), .SONG(SONG_A)
    ) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop), .loop_in(loop),
        .step_out(a_step), .tone_out(a_tone), .gate_out(a_gate), .busy_out(a_busy),
        .done_out(a_done), .note_idx_out(a_idx), .dbg_state_out(a_state)
    );

    note_sequencer #(
        .STEP_DIV(4), .BEAT_STEPS(3), .GAP_STEPS(2), .ROM_DEPTH(4), .SONG(SONG_B)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop), .loop_in(loop),
        .step_out(b_step), .tone_out(b_tone), .gate_out(b_gate), .busy_out(b_busy),
        .done_out(b_done), .note_idx_out(b_idx), .dbg_state_out(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int         run;
        int         k;
        logic [9:0] tone;
        logic       gate;
        logic [1:0] idx;
        logic       busy;
        logic       done;
        logic       step;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic add(input int run, input int k, input logic [9:0] tone, input logic gate,
                       input logic [1:0] idx, input logic busy, input logic done, input logic step);
        vec_t v;
        v.run = run; v.k = k; v.tone = tone; v.gate = gate;
        v.idx = idx; v.busy = busy; v.done = done; v.step = step;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // driver: plays song A from a start sampled at edge 4, checking table rows on the way
    task automatic run_song(input logic lp, input int glitch_k, input int kmax);
        loop = lp;
        do_reset();
        exp_q.delete();
        if (!lp) exp_q.push_back(32'd76);
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk);
            #1;
            foreach (vecs[i]) begin
                if (vecs[i].k == k &&
                    ((vecs[i].run == 0 && (!lp || k < 76)) || (vecs[i].run == 1 && lp))) begin
                    chk("tone", k, a_tone, vecs[i].tone);
                    chk("gate", k, a_gate, vecs[i].gate);
                    chk("idx",  k, a_idx,  vecs[i].idx);
                    chk("busy", k, a_busy, vecs[i].busy);
                    chk("done", k, a_done, vecs[i].done);
                    chk("step", k, a_step, vecs[i].step);
                end
            end
            if (a_done) begin
                if (exp_q.size() == 0) chk("done_unexpected", k, a_done, 0);
                else                   chk("done_edge", k, k, exp_q.pop_front());
            end
            start = (k == 3) || (k == glitch_k);
        end
        chk("done_pending", kmax, exp_q.size(), 0);
        start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int gate_steps;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;

        //  run  k   tone gate idx busy done step
        add(0,  1,    0, 0,  0,  0,   0,   0);
        add(0,  2,    0, 0,  0,  0,   0,   0);
        add(0,  3,    0, 0,  0,  0,   0,   1);
        add(0,  4,    0, 0,  0,  1,   0,   0);
        add(0,  5,    0, 0,  0,  1,   0,   0);
        add(0,  6,  100, 1,  0,  1,   0,   0);
        add(0, 15,  100, 1,  0,  1,   0,   1);
        add(0, 16,  100, 0,  0,  1,   0,   0);
        add(0, 23,  100, 0,  0,  1,   0,   1);
        add(0, 24,  100, 0,  1,  1,   0,   0);
        add(0, 26,    0, 0,  1,  1,   0,   0);
        add(0, 47,    0, 0,  1,  1,   0,   1);
        add(0, 48,    0, 0,  1,  1,   0,   0);
        add(0, 56,    0, 0,  2,  1,   0,   0);
        add(0, 58,  300, 1,  2,  1,   0,   0);
        add(0, 67,  300, 1,  2,  1,   0,   1);
        add(0, 68,  300, 0,  2,  1,   0,   0);
        add(0, 75,  300, 0,  2,  1,   0,   1);
        add(0, 76,    0, 0,  0,  0,   1,   0);
        add(0, 77,    0, 0,  0,  0,   0,   0);
        add(1, 76,  300, 0,  0,  1,   0,   0);
        add(1, 78,  100, 1,  0,  1,   0,   0);

        // outputs while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step", 0, a_step, 0);
        chk("rst_busy", 0, a_busy, 0);
        chk("rst_tone", 0, a_tone, 0);

        run_song(1'b0, 0, 80);
        run_song(1'b1, 0, 80);
        run_song(1'b0, 30, 80);

        // stop mid-note, then start and stop together while idle
        loop = 1'b0;
        do_reset();
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (a_done) done_cnt++;
            if (k == 10) chk("pre_stop_gate", k, a_gate, 1);
            if (k == 11) begin
                chk("stop_tone",  k, a_tone,  0);
                chk("stop_gate",  k, a_gate,  0);
                chk("stop_busy",  k, a_busy,  0);
                chk("stop_idx",   k, a_idx,   0);
                chk("stop_state", k, a_state, 0);
            end
            if (k == 16) chk("start_stop_busy", k, a_busy, 0);
            if (k == 40) chk("idle_busy", k, a_busy, 0);
            start = (k == 3) || (k == 15);
            stop  = (k == 10) || (k == 15);
        end
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_no_done", 40, done_cnt, 0);

        // beats=0 entry on the second instance: 48 steps of tone 200
        do_reset();
        done_cnt   = 0;
        gate_steps = 0;
        for (int k = 1; k <= 210; k++) begin
            @(posedge clk);
            #1;
            if (b_done) done_cnt++;
            if (b_gate && b_step) gate_steps++;
            if (k == 6)   chk("b0_tone_on",   k, b_tone, 200);
            if (k == 195) chk("b0_gate_late", k, b_gate, 1);
            if (k == 196) chk("b0_gate_off",  k, b_gate, 0);
            if (k == 203) chk("b0_busy_gap",  k, b_busy, 1);
            if (k == 204) begin
                chk("b0_done", k, b_done, 1);
                chk("b0_busy", k, b_busy, 0);
            end
            start = (k == 3);
        end
        start = 1'b0;
        chk("b0_gate_steps", 210, gate_steps, 48);
        chk("b0_done_count", 210, done_cnt, 1);

        // asynchronous reset in the middle of a note
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = (k == 3);
        end
        chk("pre_rst_gate", 10, a_gate, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tone", 10, a_tone, 0);
        chk("arst_gate", 10, a_gate, 0);
        chk("arst_busy", 10, a_busy, 0);
        chk("arst_idx",  10, a_idx,  0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (a_done || a_busy) done_cnt++;
        end
        chk("post_rst_idle", 20, done_cnt, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_busy", 21, a_busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  STEP_DIV, 2083, clk_in cycles per sample step.
  BEAT_STEPS, 6000, step ticks per beat.
  GAP_STEPS, 480, silent step ticks after each note; 0 means no gap.
  ROM_DEPTH, 64, number of song entries.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_in, in, 1, single clock.
  rst_n_in, in, 1, asynchronous active-low reset.
  start_in, in, 1, one-cycle start request.
  stop_in, in, 1, one-cycle abort request.
  loop_in, in, 1, level; when high, the song repeats after its last entry.
  step_out, out, 1, one-cycle sample-step pulse that feeds the oscillator step input.
  tone_out, out, 10, tone index that feeds the oscillator tone input.
  gate_out, out, 1, high while a non-rest note sounds.
  busy_out, out, 1, high whenever state is not IDLE.
  done_out, out, 1, one-cycle pulse at natural song end.
  note_idx_out, out, clog2(ROM_DEPTH), index of the current entry.

Function
REQ-003 The step divider SHALL free-run from reset, count 0..STEP_DIV-1, and wrap to 0.
REQ-004 step_out SHALL be high exactly in the cycle the divider equals STEP_DIV-1, independent of state.
REQ-005 Each ROM entry SHALL hold three fields: tone[9:0], beats[3:0] and a last flag.
REQ-006 An entry with tone=0 SHALL be a rest: gate_out low for its duration.
REQ-007 beats=0 SHALL mean 16 beats.
REQ-008 The FSM SHALL have five states: IDLE, FETCH, LOAD, PLAY, GAP.
REQ-009 In IDLE, start_in SHALL move the FSM to FETCH with note_idx=0 and busy_out=1 after the sampling edge N.
REQ-010 In FETCH, the ROM address SHALL be presented (one-cycle synchronous ROM); the FSM SHALL move to LOAD.
REQ-011 In LOAD, the entry SHALL be latched, tone_out and gate_out updated, and the FSM SHALL move to PLAY; tone_out and gate_out are therefore valid after edge N+2.
REQ-012 PLAY SHALL count step pulses that occur after PLAY is entered.
REQ-013 PLAY SHALL exit on the edge that counts pulse beats*BEAT_STEPS.
REQ-014 On PLAY exit, the FSM SHALL go to GAP if GAP_STEPS>0, otherwise directly to the advance decision.
REQ-015 GAP SHALL hold gate_out=0 with tone_out held, for GAP_STEPS step pulses.
REQ-016 At the advance decision, if the entry is neither last nor at index ROM_DEPTH-1: idx+1, go to FETCH.
REQ-017 At the advance decision, if the entry is last (or at index ROM_DEPTH-1) and loop_in=1: idx=0, go to FETCH, no done pulse.
REQ-018 At the advance decision, if the entry is last (or at index ROM_DEPTH-1) and loop_in=0: done_out pulses one cycle, go to IDLE, tone_out=0, gate_out=0.
REQ-019 start_in SHALL be ignored while busy.
REQ-020 stop_in in any non-IDLE state SHALL move the FSM to IDLE on the next edge, clear tone_out, gate_out and note_idx_out, and produce no done_out.
REQ-021 stop_in SHALL have priority over start_in when both are asserted in the same cycle.
REQ-022 The step pulse that coincides with entry to PLAY or GAP SHALL NOT be counted.
REQ-023 Duration counters SHALL be wide enough for 16*BEAT_STEPS and SHALL NOT overflow.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst_n_in low SHALL asynchronously force state=IDLE, divider=0, all counters=0, and every output to 0.
REQ-026 Reset asserted mid-song SHALL abort playback with no done_out pulse.

Structure
REQ-027 A shared package seq_pkg SHALL hold the entry struct typedef (tone, beats, last), the state enum, and the tone/beats width constants.
REQ-028 The single sub-module song_rom SHALL be a synchronous ROM of ROM_DEPTH entries with one-cycle read latency.

Verification
Bench parameters: STEP_DIV=4, BEAT_STEPS=3, GAP_STEPS=2.
REQ-029 Reset release -> step_out pulses every 4th cycle, first pulse in cycle 4; all other outputs stay 0.
REQ-030 Song {100,b1} {0,b2} {300,b1,last}, start -> tone 100 gate high for 3 steps; gap 2 steps; rest with gate low for 6 steps; gap; tone 300 for 3 steps; gap; one done_out pulse; busy_out low.
REQ-031 Same song with loop_in=1 -> note_idx_out returns to 0 after entry 2, with no done_out and busy_out staying high.
REQ-032 stop_in mid-note -> next cycle IDLE with tone_out=0 and gate_out=0, no done_out; start_in and stop_in together in IDLE -> the FSM stays IDLE.
REQ-033 start_in pulsed while busy -> ignored; an entry with beats=0 -> plays 48 steps.
REQ-034 rst_n_in asserted mid-PLAY between clock edges -> outputs clear immediately; after release, playback stays idle until start_in.
